// File: rtl/axi_lite_reg_slave_if.sv
// axi_lite_reg_slave_if: AXI4-Lite bus bundle (15-bit address, 32-bit data) for the register slave
interface axi_lite_reg_slave_if;
   logic [14:0] axi_awaddr;
   logic        axi_awvalid;
   logic        axi_awready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wvalid;
   logic        axi_wready;
   logic [1:0]  axi_bresp;
   logic        axi_bvalid;
   logic        axi_bready;
   logic [14:0] axi_araddr;
   logic        axi_arvalid;
   logic        axi_arready;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rvalid;
   logic        axi_rready;
   modport master(
      output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      output axi_araddr, axi_arvalid, axi_rready,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
      input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
   );
   modport slave(
      input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
      input  axi_araddr, axi_arvalid, axi_rready,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid,
      output axi_arready, axi_rdata, axi_rresp, axi_rvalid
   );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register slave (VERSION, SCRATCH, CTRL, STATUS, PULSE, WR_COUNT).
// Define AXI_REG_WSTRB_EN to honour byte strobes on SCRATCH, CTRL and PULSE writes.
module axi_lite_reg_slave #(
   parameter logic [31:0] VERSION = 32'h20251123
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_lite_reg_slave_if.slave  axi,
   input  logic [31:0]          status_in,
   output logic [31:0]          ctrl_out,
   output logic [31:0]          pulse_out
);
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;
   logic        aw_held, w_held, commit, w_map, r_map;
   logic [14:0] aw_addr;
   logic [31:0] w_data, w_mask, scratch, wr_count, r_val;
   logic [3:0]  w_strb, w_idx, r_idx;
   logic [0:0]  r_state;
   function automatic logic mapped(input logic [14:0] a);
      return a[14:6] == 9'd0 && a[1:0] == 2'd0 && a[5:2] <= 4'd5;
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
      return (old & ~m) | (d & m);
   endfunction
`ifdef AXI_REG_WSTRB_EN
   assign w_mask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
`else
   logic unused_strb;
   assign unused_strb = ^w_strb;
   assign w_mask = '1;
`endif
   assign axi.axi_awready = !aw_held && !axi.axi_bvalid;
   assign axi.axi_wready  = !w_held && !axi.axi_bvalid;
   assign axi.axi_arready = r_state == R_IDLE;
   assign axi.axi_rvalid  = r_state == R_DATA;
   assign commit = aw_held && w_held;
   assign w_idx  = aw_addr[5:2];
   assign w_map  = mapped(aw_addr);
   assign r_idx  = axi.axi_araddr[5:2];
   always_comb begin
      r_map = mapped(axi.axi_araddr);
      r_val = !r_map       ? 32'd0 :
              r_idx == 4'd0 ? VERSION :
              r_idx == 4'd1 ? scratch :
              r_idx == 4'd2 ? ctrl_out :
              r_idx == 4'd3 ? status_in :
              r_idx == 4'd5 ? wr_count : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held        <= 1'b0;
         w_held         <= 1'b0;
         aw_addr        <= '0;
         w_data         <= '0;
         w_strb         <= '0;
         axi.axi_bvalid <= 1'b0;
         axi.axi_bresp  <= 2'b00;
         axi.axi_rdata  <= '0;
         axi.axi_rresp  <= 2'b00;
         r_state        <= R_IDLE;
         scratch        <= '0;
         ctrl_out       <= '0;
         wr_count       <= '0;
         pulse_out      <= '0;
      end else begin
         pulse_out <= '0;
         if (axi.axi_awvalid && axi.axi_awready) begin
            aw_held <= 1'b1;
            aw_addr <= axi.axi_awaddr;
         end
         if (axi.axi_wvalid && axi.axi_wready) begin
            w_held <= 1'b1;
            w_data <= axi.axi_wdata;
            w_strb <= axi.axi_wstrb;
         end
         // holds only fill while bvalid is low, so commit and the B handshake never coincide
         if (commit) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            axi.axi_bvalid <= 1'b1;
            axi.axi_bresp  <= w_map ? 2'b00 : 2'b10;
            if (w_map) begin
               wr_count <= wr_count + 32'd1;
               if (w_idx == 4'd1) scratch <= merge(scratch, w_data, w_mask);
               if (w_idx == 4'd2) ctrl_out <= merge(ctrl_out, w_data, w_mask);
               if (w_idx == 4'd4) pulse_out <= w_data & w_mask;
            end
         end else if (axi.axi_bvalid && axi.axi_bready) begin
            axi.axi_bvalid <= 1'b0;
         end
         if (axi.axi_arvalid && axi.axi_arready) begin
            r_state       <= R_DATA;
            axi.axi_rdata <= r_val;
            axi.axi_rresp <= r_map ? 2'b00 : 2'b10;
         end else if (r_state == R_DATA && axi.axi_rready) begin
            r_state <= R_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: table-driven register access vectors plus hand-written multi-cycle sequences.
module tb_axi_lite_reg_slave;
   typedef struct {
      logic        wr;
      logic [14:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic [1:0]  resp;
   } vec_t;
`ifdef AXI_REG_WSTRB_EN
   localparam logic [31:0] STRB_EXP = 32'hFFFF00FF;
`else
   localparam logic [31:0] STRB_EXP = 32'h00000000;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] status_in = 32'h13579BDF;
   logic [31:0] ctrl_out, pulse_out;
   int          checks = 0;
   int          errors = 0;
   vec_t        vec [22];
   axi_lite_reg_slave_if bus();
   axi_lite_reg_slave #(.VERSION(32'h20251123)) dut (
      .clk(clk), .rst(rst), .axi(bus), .status_in(status_in), .ctrl_out(ctrl_out), .pulse_out(pulse_out)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp, output int lat);
      @(negedge clk);
      bus.axi_awaddr = a;
      bus.axi_wdata = d;
      bus.axi_wstrb = s;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid = 1'b1;
      lat = 0;
      for (int i = 0; i < 20 && !(bus.axi_awready && bus.axi_wready); i++) @(negedge clk);
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      bus.axi_wvalid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.axi_bvalid) begin
            lat = i;
            break;
         end
      end
      resp = bus.axi_bresp;
      if (bus.axi_bready) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic rd(input logic [14:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
      @(negedge clk);
      bus.axi_araddr = a;
      bus.axi_arvalid = 1'b1;
      lat = 0;
      for (int i = 0; i < 20 && !bus.axi_arready; i++) @(negedge clk);
      @(posedge clk);
      #1 bus.axi_arvalid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.axi_rvalid) begin
            lat = i;
            break;
         end
      end
      d = bus.axi_rdata;
      resp = bus.axi_rresp;
      if (bus.axi_rready) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic rd_chk(input string name, input logic [14:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      rd(a, d, r, lat);
      chk({name, " rdata"}, d, exp);
      chk({name, " rresp"}, {30'd0, r}, 32'd0);
   endtask
   task automatic wr_ok(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [1:0] r;
      int         lat;
      wr(a, d, s, r, lat);
      chk("wr_ok bresp", {30'd0, r}, 32'd0);
   endtask
   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      vec = '{
         '{1'b1, 15'h0004, 32'hCAFEF00D, 32'h0,        2'b00},
         '{1'b0, 15'h0004, 32'h0,        32'hCAFEF00D, 2'b00},
         '{1'b0, 15'h0000, 32'h0,        32'h20251123, 2'b00},
         '{1'b0, 15'h0040, 32'h0,        32'h0,        2'b10},
         '{1'b1, 15'h003C, 32'h00001234, 32'h0,        2'b10},
         '{1'b0, 15'h0014, 32'h0,        32'd1,        2'b00},
         '{1'b1, 15'h0000, 32'hFFFFFFFF, 32'h0,        2'b00},
         '{1'b0, 15'h0000, 32'h0,        32'h20251123, 2'b00},
         '{1'b1, 15'h0008, 32'hA5A50001, 32'h0,        2'b00},
         '{1'b0, 15'h0008, 32'h0,        32'hA5A50001, 2'b00},
         '{1'b0, 15'h000C, 32'h0,        32'h13579BDF, 2'b00},
         '{1'b1, 15'h0010, 32'h00000000, 32'h0,        2'b00},
         '{1'b0, 15'h0010, 32'h0,        32'h0,        2'b00},
         '{1'b1, 15'h000A, 32'h00000000, 32'h0,        2'b10},
         '{1'b0, 15'h0008, 32'h0,        32'hA5A50001, 2'b00},
         '{1'b0, 15'h0018, 32'h0,        32'h0,        2'b10},
         '{1'b0, 15'h0014, 32'h0,        32'd4,        2'b00},
         '{1'b1, 15'h4008, 32'h12345678, 32'h0,        2'b10},
         '{1'b0, 15'h0008, 32'h0,        32'hA5A50001, 2'b00},
         '{1'b0, 15'h0014, 32'h0,        32'd4,        2'b00},
         '{1'b1, 15'h0014, 32'h00000000, 32'h0,        2'b00},
         '{1'b0, 15'h0014, 32'h0,        32'd5,        2'b00}
      };
      bus.axi_awaddr = '0;
      bus.axi_awvalid = 1'b0;
      bus.axi_wdata = '0;
      bus.axi_wstrb = 4'hF;
      bus.axi_wvalid = 1'b0;
      bus.axi_bready = 1'b1;
      bus.axi_araddr = '0;
      bus.axi_arvalid = 1'b0;
      bus.axi_rready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst awready", {31'd0, bus.axi_awready}, 32'd1);
      chk("rst wready", {31'd0, bus.axi_wready}, 32'd1);
      chk("rst arready", {31'd0, bus.axi_arready}, 32'd1);
      chk("rst bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
      chk("rst rvalid", {31'd0, bus.axi_rvalid}, 32'd0);
      chk("rst ctrl_out", ctrl_out, 32'd0);
      chk("rst pulse_out", pulse_out, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      foreach (vec[i]) begin
         if (vec[i].wr) begin
            wr(vec[i].addr, vec[i].data, 4'hF, r, lat);
            chk($sformatf("vec%0d bresp", i), {30'd0, r}, {30'd0, vec[i].resp});
            chk($sformatf("vec%0d blat", i), lat, 32'd2);
         end else begin
            rd(vec[i].addr, d, r, lat);
            chk($sformatf("vec%0d rdata", i), d, vec[i].exp);
            chk($sformatf("vec%0d rresp", i), {30'd0, r}, {30'd0, vec[i].resp});
            chk($sformatf("vec%0d rlat", i), lat, 32'd1);
         end
      end
      chk("ctrl_out after table", ctrl_out, 32'hA5A50001);
      // W first, AW three cycles later
      @(negedge clk);
      bus.axi_wdata = 32'h5;
      bus.axi_wstrb = 4'hF;
      bus.axi_wvalid = 1'b1;
      chk("wfirst wready", {31'd0, bus.axi_wready}, 32'd1);
      @(posedge clk);
      #1 bus.axi_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wfirst no bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
         chk("wfirst wready low", {31'd0, bus.axi_wready}, 32'd0);
      end
      bus.axi_awaddr = 15'h0008;
      bus.axi_awvalid = 1'b1;
      chk("wfirst awready", {31'd0, bus.axi_awready}, 32'd1);
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      @(negedge clk);
      chk("wfirst ctrl pre", ctrl_out, 32'hA5A50001);
      chk("wfirst bvalid pre", {31'd0, bus.axi_bvalid}, 32'd0);
      @(negedge clk);
      chk("wfirst ctrl post", ctrl_out, 32'h5);
      chk("wfirst bvalid post", {31'd0, bus.axi_bvalid}, 32'd1);
      @(posedge clk);
      #1;
      rd_chk("wfirst wr_count", 15'h0014, 32'd6);
      // B backpressure, awvalid held one cycle past its handshake
      bus.axi_bready = 1'b0;
      @(negedge clk);
      bus.axi_awaddr = 15'h0004;
      bus.axi_wdata = 32'h11111111;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_wvalid = 1'b0;
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp bvalid", {31'd0, bus.axi_bvalid}, 32'd1);
         chk("bp awready", {31'd0, bus.axi_awready}, 32'd0);
         chk("bp wready", {31'd0, bus.axi_wready}, 32'd0);
      end
      bus.axi_bready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp bvalid cleared", {31'd0, bus.axi_bvalid}, 32'd0);
      rd_chk("bp wr_count", 15'h0014, 32'd7);
      rd_chk("bp scratch", 15'h0004, 32'h11111111);
      // PULSE strobe lasts exactly one cycle
      @(negedge clk);
      bus.axi_awaddr = 15'h0010;
      bus.axi_wdata = 32'h81;
      bus.axi_wstrb = 4'b0001;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      bus.axi_wvalid = 1'b0;
      @(negedge clk);
      chk("pulse before", pulse_out, 32'h0);
      @(negedge clk);
      chk("pulse commit", pulse_out, 32'h81);
      @(negedge clk);
      chk("pulse after", pulse_out, 32'h0);
      wr_ok(15'h0004, 32'hFFFFFFFF, 4'hF);
      wr_ok(15'h0004, 32'h00000000, 4'b0010);
      rd_chk("strb scratch", 15'h0004, STRB_EXP);
      // read handshake on the commit edge sees the old value
      @(negedge clk);
      bus.axi_awaddr = 15'h0004;
      bus.axi_wdata = 32'h77777777;
      bus.axi_wstrb = 4'hF;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      bus.axi_wvalid = 1'b0;
      bus.axi_araddr = 15'h0004;
      bus.axi_arvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_arvalid = 1'b0;
      @(negedge clk);
      chk("race rvalid", {31'd0, bus.axi_rvalid}, 32'd1);
      chk("race rdata", bus.axi_rdata, STRB_EXP);
      chk("race bvalid", {31'd0, bus.axi_bvalid}, 32'd1);
      @(posedge clk);
      #1;
      rd_chk("race new scratch", 15'h0004, 32'h77777777);
      rd_chk("race wr_count", 15'h0014, 32'd11);
      // reset while both responses are pending
      bus.axi_bready = 1'b0;
      bus.axi_rready = 1'b0;
      @(negedge clk);
      bus.axi_awaddr = 15'h0008;
      bus.axi_wdata = 32'h9;
      bus.axi_awvalid = 1'b1;
      bus.axi_wvalid = 1'b1;
      bus.axi_araddr = 15'h000C;
      bus.axi_arvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      bus.axi_wvalid = 1'b0;
      bus.axi_arvalid = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("prerst bvalid", {31'd0, bus.axi_bvalid}, 32'd1);
      chk("prerst rvalid", {31'd0, bus.axi_rvalid}, 32'd1);
      chk("prerst ctrl", ctrl_out, 32'h9);
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
      chk("midrst rvalid", {31'd0, bus.axi_rvalid}, 32'd0);
      chk("midrst ctrl", ctrl_out, 32'h0);
      chk("midrst awready", {31'd0, bus.axi_awready}, 32'd1);
      chk("midrst arready", {31'd0, bus.axi_arready}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      bus.axi_bready = 1'b1;
      bus.axi_rready = 1'b1;
      rd_chk("postrst ctrl", 15'h0008, 32'h0);
      rd_chk("postrst wr_count", 15'h0014, 32'h0);
      // a W accepted before reset must not pair with a later AW
      @(negedge clk);
      bus.axi_wdata = 32'h3;
      bus.axi_wvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_wvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      bus.axi_awaddr = 15'h0008;
      bus.axi_awvalid = 1'b1;
      @(posedge clk);
      #1 bus.axi_awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("discard bvalid", {31'd0, bus.axi_bvalid}, 32'd0);
         chk("discard ctrl", ctrl_out, 32'h0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named clk and rst as below.
REQ-002 Parameter: VERSION, 32'h20251123, constant returned by the VERSION register.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 axi_awaddr/axi_awvalid/axi_awready  in/in/out  15/1/1  write address channel.
REQ-006 axi_wdata/axi_wstrb/axi_wvalid/axi_wready  in/in/in/out  32/4/1/1  write data channel.
REQ-007 axi_bresp/axi_bvalid/axi_bready  out/out/in  2/1/1  write response channel.
REQ-008 axi_araddr/axi_arvalid/axi_arready  in/in/out  15/1/1  read address channel.
REQ-009 axi_rdata/axi_rresp/axi_rvalid/axi_rready  out/out/out/in  32/2/1/1  read data channel.
REQ-010 status_in  in  32  live status word, sampled when read.
REQ-011 ctrl_out  out  32  CTRL register contents.
REQ-012 pulse_out  out  32  one-cycle strobes from PULSE writes.

Function
REQ-013 Register map: mapped only if addr[14:6]==0 and addr[1:0]==0, with word index addr[5:2] as follows.
REQ-014 Map: 0x00 VERSION RO; 0x04 SCRATCH RW; 0x08 CTRL RW; 0x0C STATUS RO = status_in; 0x10 PULSE WO, reads 0; 0x14 WR_COUNT RO.
REQ-015 Any other address SHALL be unmapped: response SLVERR (2'b10), read data 0, and no state change.
REQ-016 Writes to a mapped RO register SHALL be ignored and answered OKAY (2'b00).
REQ-017 AW and W SHALL be accepted independently.
REQ-018 axi_awready = !aw_held && !axi_bvalid; axi_wready = !w_held && !axi_bvalid.
REQ-019 On a handshake, the block SHALL latch the address or data (with strobe) and set aw_held or w_held.
REQ-020 Commit: in the first cycle with aw_held && w_held, the block SHALL update the register, clear both holds and assert axi_bvalid.
REQ-021 Write latency: simultaneous AW+W handshake at edge N gives commit and axi_bvalid=1 at edge N+1.
REQ-022 axi_bvalid/axi_bresp SHALL hold until axi_bvalid && axi_bready, then clear on that edge.
REQ-023 No new AW/W SHALL be accepted while axi_bvalid=1.
REQ-024 A master holding awvalid/wvalid one cycle past its handshake SHALL NOT cause a second write.
REQ-025 Read FSM R_IDLE -> R_DATA: axi_arready = (state==R_IDLE).
REQ-026 On an AR handshake, the block SHALL register axi_rdata/axi_rresp from current register values and set axi_rvalid at the next edge (latency 1).
REQ-027 axi_rvalid and axi_rdata SHALL stay stable until axi_rready, then return to R_IDLE.
REQ-028 The read and write channels SHALL operate concurrently.
REQ-029 A read handshake on the same edge as a write commit to the same register SHALL return the pre-commit value.
REQ-030 PULSE write: pulse_out SHALL equal the written data for exactly the commit cycle, and 0 otherwise.
REQ-031 WR_COUNT SHALL increment by 1 per committed write to a mapped address, wrapping 0xFFFFFFFF -> 0.

Reset
REQ-032 While rst=1, the block SHALL clear holds, set axi_bvalid=0, axi_rvalid=0, axi_bresp=0, axi_rresp=0, axi_rdata=0 and read FSM=R_IDLE.
REQ-033 While rst=1, the block SHALL set SCRATCH=0, CTRL=0, WR_COUNT=0 and pulse_out=0.
REQ-034 While rst=1, axi_awready, axi_wready and axi_arready SHALL read 1 per REQ-018 and REQ-025.
REQ-035 A reset mid-transaction SHALL discard the pending write or read without committing and without issuing a response.

Configuration
REQ-036 With AXI_REG_WSTRB_EN defined, writes to RW registers SHALL update only the bytes whose axi_wstrb bit is 1.
REQ-037 With AXI_REG_WSTRB_EN defined, a PULSE write SHALL strobe only the enabled bytes.
REQ-038 Without AXI_REG_WSTRB_EN, axi_wstrb SHALL be ignored and full 32-bit words written.

Verification
REQ-039 Write 0x04 <= 0xCAFEF00D with AW+W together, then read 0x04 -> bvalid one cycle later, bresp=00, rdata=0xCAFEF00D, rresp=00.
REQ-040 W first, then AW three cycles later, to 0x08 with data 0x5 -> no bvalid before AW, ctrl_out=0x5 on the edge after AW, then WR_COUNT reads 1.
REQ-041 Read 0x00 and 0x40; write 0x3C -> 0x20251123/OKAY; 0/SLVERR; SLVERR with WR_COUNT unchanged.
REQ-042 Hold bready=0 for 5 cycles after a write -> bvalid held, awready=wready=0 throughout; awvalid held one cycle after handshake causes no second commit.
REQ-043 Write PULSE 0x81 with wstrb=4'b0001 -> pulse_out=0x81 for exactly one cycle; with AXI_REG_WSTRB_EN, SCRATCH 0xFFFFFFFF written 0 with wstrb=4'b0010 reads 0xFFFF00FF.
REQ-044 Assert rst while bvalid and rvalid are pending -> both drop, CTRL=0, WR_COUNT=0, and the next read of 0x08 returns 0.
